// File: rtl/octal_capture_sequencer_if.sv
// Serialized sample stream carrying one ADC channel word per beat.
// The master drives data, chan, last and valid; the slave drives ready.
interface octal_capture_sequencer_if #(
  parameter int unsigned DW  = 14,
  parameter int unsigned CHW = 3
) ();
  logic [DW-1:0]  data;
  logic [CHW-1:0] chan;
  logic           last;
  logic           valid;
  logic           ready;

  modport master (output data, chan, last, valid, input ready);
  modport slave  (input data, chan, last, valid, output ready);
endinterface

// File: rtl/octal_capture_sequencer.sv
// Latches all ADC channels on a common strobe and serializes the enabled ones
// onto one valid/ready stream, counting frames and flagging dropped strobes.
module octal_capture_sequencer #(
  parameter int unsigned NCH = 8,
  parameter int unsigned DW  = 14,
  parameter int unsigned FCW = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm_i,
  input  logic                   abort_i,
  input  logic [FCW-1:0]         frame_count_i,
  input  logic [NCH-1:0]         ch_enable_i,
  input  logic [NCH-1:0]         flip_mask_i,
  input  logic                   sample_strobe_i,
  input  logic [NCH*DW-1:0]      adc_data_i,
  octal_capture_sequencer_if.master out_if,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overrun_o,
  output logic [FCW-1:0]         frames_done_o
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SHIFT, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [FCW-1:0]      fc_q, fc_d;
  logic [NCH-1:0]      en_q, en_d;
  logic [NCH-1:0]      flip_q, flip_d;
  logic [NCH*DW-1:0]   bank_q, bank_d;
  logic [NCH-1:0]      pend_q, pend_d;
  logic [DW-1:0]       data_q, data_d;
  logic [CHW-1:0]      chan_q, chan_d;
  logic                last_q, last_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic [FCW-1:0]      frames_q, frames_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                frame_end;
  logic                final_frame;
  logic                load_adc;
  logic                load_beat;

  logic [NCH*DW-1:0]   src_bank;
  logic [NCH-1:0]      src_mask;
  logic [NCH-1:0]      rest_mask;
  logic [DW-1:0]       words [NCH];
  logic [CHW-1:0]      sel_idx;
  logic [DW-1:0]       sel_word;
  logic [DW-1:0]       beat_data;

  assign accept      = valid_q & out_if.ready;
  assign frame_end   = (state_q == ST_SHIFT) & accept & last_q;
  assign final_frame = (fc_q != '0) && ((frames_q + FCW'(1)) == fc_q);
  // Next beat comes from the live ADC bus when a new frame starts this cycle
  assign load_adc    = !abort_i && sample_strobe_i &&
                       ((state_q == ST_WAIT) || (frame_end && !final_frame));

  // Pick the lowest pending channel and apply its optional bit reversal
  always_comb begin
    src_bank = load_adc ? adc_data_i : bank_q;
    src_mask = load_adc ? en_q : pend_q;
    sel_idx  = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (src_mask[i]) sel_idx = CHW'(i);
    end
    for (int i = 0; i < int'(NCH); i++) begin
      words[i] = src_bank[DW*i +: DW];
    end
    sel_word  = words[sel_idx];
    rest_mask = src_mask & ~(NCH'(1) << sel_idx);
    beat_data = sel_word;
    if (flip_q[sel_idx]) begin
      for (int j = 0; j < int'(DW); j++) beat_data[j] = sel_word[int'(DW) - 1 - j];
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    fc_d      = fc_q;
    en_d      = en_q;
    flip_d    = flip_q;
    bank_d    = bank_q;
    pend_d    = pend_q;
    data_d    = data_q;
    chan_d    = chan_q;
    last_d    = last_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    frames_d  = frames_q;
    load_beat = 1'b0;

    if (abort_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_i && (ch_enable_i != '0)) begin
            state_d   = ST_WAIT;
            fc_d      = frame_count_i;
            en_d      = ch_enable_i;
            flip_d    = flip_mask_i;
            overrun_d = 1'b0;
            frames_d  = '0;
          end
        end
        ST_WAIT: begin
          if (sample_strobe_i) begin
            state_d   = ST_SHIFT;
            load_beat = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (frame_end) begin
            frames_d = frames_q + FCW'(1);
            if (final_frame) begin
              state_d = ST_DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else if (sample_strobe_i) begin
              load_beat = 1'b1;
            end else begin
              state_d = ST_WAIT;
              valid_d = 1'b0;
            end
          end else begin
            if (sample_strobe_i) overrun_d = 1'b1;
            if (accept) load_beat = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (load_beat) begin
      if (load_adc) bank_d = adc_data_i;
      pend_d  = rest_mask;
      data_d  = beat_data;
      chan_d  = sel_idx;
      last_d  = (rest_mask == '0);
      valid_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      fc_q      <= '0;
      en_q      <= '0;
      flip_q    <= '0;
      bank_q    <= '0;
      pend_q    <= '0;
      data_q    <= '0;
      chan_q    <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      frames_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fc_q      <= fc_d;
      en_q      <= en_d;
      flip_q    <= flip_d;
      bank_q    <= bank_d;
      pend_q    <= pend_d;
      data_q    <= data_d;
      chan_q    <= chan_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      frames_q  <= frames_d;
      busy_q    <= busy_d;
    end
  end

  assign out_if.data  = data_q;
  assign out_if.chan  = chan_q;
  assign out_if.last  = last_q;
  assign out_if.valid = valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign overrun_o     = overrun_q;
  assign frames_done_o = frames_q;

endmodule
